// File: rtl/systolic_pkg.sv
// systolic_pkg: definitions shared by the systolic-array control blocks.
//   feed_state_e : sequencing states of the west-edge feed scheduler
//   FEED_*       : default feeder geometry (byte-serial 56-bit bursts)
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } feed_state_e;

  localparam int FEED_BYTE_W  = 8;
  localparam int FEED_BURST_W = 56;
  localparam int FEED_BYTES   = FEED_BURST_W / FEED_BYTE_W;

endpackage

// File: rtl/skew_en_gen.sv
// skew_en_gen: turns the current stream step t into the diagonally skewed
// feeder enable vector. Row i is enabled for steps i .. i+BYTES_PER_BURST-1.
// Output is registered.
//   clk, rst : clock, async active-high reset
//   t        : step index being issued in the coming cycle
//   active   : a step is issued in the coming cycle (not stalled / gapped)
//   en       : per-row shift enable, registered
module skew_en_gen #(
  parameter int N_ROWS          = 4,
  parameter int BYTES_PER_BURST = 7,
  parameter int T_W             = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [T_W-1:0]    t,
  input  logic              active,
  output logic [N_ROWS-1:0] en
);

  logic [N_ROWS-1:0] en_d;

  for (genvar i = 0; i < N_ROWS; i++) begin : g_row
    assign en_d[i] = active && (32'(t) >= 32'(i)) &&
                     (32'(t) < 32'(i + BYTES_PER_BURST));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) en <= '0;
    else     en <= en_d;
  end

endmodule

// File: rtl/feed_scheduler.sv
// feed_scheduler: sequences the west-edge byte feeders of the systolic array.
// A start in IDLE gives LOAD (feed_load + mac_clear), a STREAM of skewed
// shift enables, a DRAIN wait for the array pipeline, and a done pulse.
//   clk, reset   : clock, async active-high reset (aborts a burst, no done)
//   start        : burst request, sampled only in IDLE
//   stall        : freezes streaming while high (ignored outside STREAM)
//   busy         : high in every state but IDLE
//   feed_load    : one-cycle load pulse to all feeders
//   feed_en      : per-feeder shift enable
//   mac_clear    : accumulator clear, coincident with feed_load
//   done         : one-cycle completion pulse
// Build option: define SHIFT_GAP_EN to follow every issued step with an idle
// gap cycle (stall in either cycle stretches the step).
// All outputs are registered; the FSM decides next-cycle outputs each edge.
module feed_scheduler import systolic_pkg::*; #(
  parameter int N_ROWS          = 4,
  parameter int BYTES_PER_BURST = FEED_BYTES,
  parameter int DRAIN_CYCLES    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic [N_ROWS-1:0] feed_load,
  output logic [N_ROWS-1:0] feed_en,
  output logic              mac_clear,
  output logic              done
);

  localparam int T_W = $clog2(BYTES_PER_BURST + N_ROWS);
  localparam int D_W = $clog2(DRAIN_CYCLES + 1);
  // t counts issued steps; reaching T_LAST+1 means the last step is out.
  localparam logic [T_W-1:0] T_END = T_W'(BYTES_PER_BURST + N_ROWS - 1);

  if (N_ROWS < 1) begin : g_chk_rows
    $error("feed_scheduler: N_ROWS must be >= 1");
  end
  if (BYTES_PER_BURST < 1) begin : g_chk_bytes
    $error("feed_scheduler: BYTES_PER_BURST must be >= 1");
  end
  if (DRAIN_CYCLES < 1) begin : g_chk_drain
    $error("feed_scheduler: DRAIN_CYCLES must be >= 1");
  end

  feed_state_e    state;
  logic [T_W-1:0] t;
  logic [D_W-1:0] dcnt;
  logic           last_done;   // every step issued, nothing left in STREAM
  logic           stream_next; // the coming cycle belongs to STREAM
  logic           issue;       // the coming cycle carries a step's enables

`ifdef SHIFT_GAP_EN
  logic gap; // an idle gap cycle is owed before the next step
  assign last_done = (t == T_END) && !gap;
  assign issue     = stream_next && !gap && !stall;
`else
  assign last_done = (t == T_END);
  assign issue     = stream_next && !stall;
`endif

  assign stream_next = (state == LOAD) || ((state == STREAM) && !last_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      t         <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      feed_load <= '0;
      mac_clear <= 1'b0;
      done      <= 1'b0;
`ifdef SHIFT_GAP_EN
      gap       <= 1'b0;
`endif
    end else begin
      feed_load <= '0;
      mac_clear <= 1'b0;
      done      <= 1'b0;
      if (issue) t <= t + 1'b1;
`ifdef SHIFT_GAP_EN
      // Gap is entered unconditionally after a step and lasts until a
      // cycle ends without stall.
      if (issue)       gap <= 1'b1;
      else if (!stall) gap <= 1'b0;
`endif
      case (state)
        IDLE: if (start) begin
          state     <= LOAD;
          feed_load <= '1;
          mac_clear <= 1'b1;
          busy      <= 1'b1;
          t         <= '0;
          dcnt      <= '0;
        end
        LOAD:   state <= STREAM;
        STREAM: if (last_done) begin
          state <= DRAIN;
          dcnt  <= D_W'(1);
        end
        DRAIN: begin
          if (dcnt == D_W'(DRAIN_CYCLES)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  skew_en_gen #(
    .N_ROWS(N_ROWS),
    .BYTES_PER_BURST(BYTES_PER_BURST),
    .T_W(T_W)
  ) u_skew (
    .clk(clk),
    .rst(reset),
    .t(t),
    .active(issue),
    .en(feed_en)
  );

endmodule

// File: tb/tb_feed_scheduler.sv
module tb_feed_scheduler;
  localparam int NR = 4, NB = 7, ND = 4, MAXC = 700;
`ifdef SHIFT_GAP_EN
  localparam int STRIDE = 2, DONE_AT = 26, LOAD2_AT = 28, DONE_STALL = 28;
`else
  localparam int STRIDE = 1, DONE_AT = 16, LOAD2_AT = 18, DONE_STALL = 18;
`endif
  localparam logic [NR-1:0] TBL [10] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF,
                                         4'hF, 4'hF, 4'hE, 4'hC, 4'h8};

  logic clk = 1'b0;
  logic reset, start, stall, busy, mac_clear, done;
  logic [NR-1:0] feed_load, feed_en;

  always #5 clk = ~clk;

  feed_scheduler #(.N_ROWS(NR), .BYTES_PER_BURST(NB), .DRAIN_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .busy(busy),
    .feed_load(feed_load), .feed_en(feed_en), .mac_clear(mac_clear), .done(done)
  );

  int total = 0, bad = 0;
  bit in_start [MAXC];
  bit in_stall [MAXC];
  logic [NR-1:0] x_en [MAXC], x_load [MAXC], o_en [MAXC], o_load [MAXC];
  logic x_clr [MAXC], x_busy [MAXC], x_done [MAXC];
  logic o_clr [MAXC], o_busy [MAXC], o_done [MAXC];

  // enables of stream step k: row i works on steps i .. i+NB-1
  function automatic logic [NR-1:0] step_pat(int k);
    logic [NR-1:0] p;
    for (int i = 0; i < NR; i++) p[i] = (k >= i) && (k < i + NB);
    return p;
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin in_start[c] = 0; in_stall[c] = 0; end
  endtask

  // Reference schedule built from the whole input timeline. Inputs driven in
  // cycle c act on the outputs of cycle c+1.
  task automatic plan(int nc);
    int c, s, k, u;
    for (int i = 0; i < MAXC; i++) begin
      x_en[i] = '0; x_load[i] = '0; x_clr[i] = 0; x_busy[i] = 0; x_done[i] = 0;
    end
    c = 0;
    while (c < nc) begin
      if (!in_start[c]) begin c++; continue; end
      if (c + 1 < MAXC) begin x_load[c+1] = '1; x_clr[c+1] = 1; x_busy[c+1] = 1; end
      s = c + 2; k = 0;
      while (k < NB + NR - 1 && s < MAXC) begin
        x_busy[s] = 1;
        if (in_stall[s-1]) s++;
        else begin
          x_en[s] = step_pat(k); k++;
`ifdef SHIFT_GAP_EN
          u = s;
          while (u < MAXC - 2 && in_stall[u]) u++;
          for (int z = s + 1; z <= u + 1 && z < MAXC; z++) x_busy[z] = 1;
          s = u + 2;
`else
          u = s;
          s = u + 1;
`endif
        end
      end
      for (int z = s; z <= s + ND && z < MAXC; z++) x_busy[z] = 1;
      if (s + ND < MAXC) x_done[s+ND] = 1;
      c = s + ND + 1;
    end
  endtask

  task automatic drive(int nc, bit do_reset);
    if (do_reset) begin
      reset = 1; start = 0; stall = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
    end
    for (int c = 0; c < nc; c++) begin
      @(posedge clk); #1;
      start = in_start[c]; stall = in_stall[c];
      @(negedge clk);
      o_en[c] = feed_en; o_load[c] = feed_load; o_clr[c] = mac_clear;
      o_busy[c] = busy; o_done[c] = done;
    end
    start = 0; stall = 0;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; stall = 0;
    #1;
    total++;
    if ({busy, feed_load, feed_en, mac_clear, done} !== '0) begin
      bad++; $display("FAIL reset_state got=%b want=0", {busy, feed_load, feed_en, mac_clear, done});
    end
    clear_stim(); in_start[0] = 1; plan(7);
    drive(7, 1);
    total++;
    if (o_en[6] !== x_en[6] || o_busy[6] !== 1'b1) begin
      bad++; $display("FAIL pre_abort_en got=%h want=%h", o_en[6], x_en[6]);
    end
    reset = 1; // asynchronous, mid-cycle, mid-STREAM
    #1;
    total++;
    if ({busy, feed_load, feed_en, mac_clear, done} !== '0) begin
      bad++; $display("FAIL async_abort got=%b want=0", {busy, feed_load, feed_en, mac_clear, done});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL abort_no_done c=%0d done=%b busy=%b want 0", c, done, busy);
      end
    end
    @(posedge clk); #1 reset = 0;
    clear_stim(); in_start[0] = 1; plan(30);
    drive(30, 0);
    for (int c = 0; c < 30; c++) begin
      total++;
      if ({o_en[c], o_load[c], o_clr[c], o_busy[c], o_done[c]} !==
          {x_en[c], x_load[c], x_clr[c], x_busy[c], x_done[c]}) begin
        bad++; $display("FAIL after_reset c=%0d got=%b want=%b", c,
          {o_en[c], o_load[c], o_clr[c], o_busy[c], o_done[c]},
          {x_en[c], x_load[c], x_clr[c], x_busy[c], x_done[c]});
      end
    end
  endtask

  task automatic test_basic();
    int cnt, sum;
    clear_stim(); in_start[0] = 1; plan(40);
    drive(40, 1);
    for (int c = 0; c < 40; c++) begin
      total++;
      if ({o_en[c], o_load[c], o_clr[c], o_busy[c], o_done[c]} !==
          {x_en[c], x_load[c], x_clr[c], x_busy[c], x_done[c]}) begin
        bad++; $display("FAIL basic c=%0d got=%b want=%b", c,
          {o_en[c], o_load[c], o_clr[c], o_busy[c], o_done[c]},
          {x_en[c], x_load[c], x_clr[c], x_busy[c], x_done[c]});
      end
    end
    total++;
    if (o_load[1] !== 4'hF || o_clr[1] !== 1'b1) begin
      bad++; $display("FAIL basic_load got=%h/%b want=f/1", o_load[1], o_clr[1]);
    end
    for (int j = 0; j < 10; j++) begin
      total++;
      if (o_en[2+STRIDE*j] !== TBL[j]) begin
        bad++; $display("FAIL basic_table j=%0d got=%b want=%b", j, o_en[2+STRIDE*j], TBL[j]);
      end
    end
    total++;
    if (o_done[DONE_AT] !== 1'b1 || o_busy[DONE_AT+1] !== 1'b0) begin
      bad++; $display("FAIL basic_done got=%b/%b want=1/0", o_done[DONE_AT], o_busy[DONE_AT+1]);
    end
    sum = 0;
    for (int i = 0; i < NR; i++) begin
      cnt = 0;
      for (int c = 0; c < 40; c++) cnt += int'(o_en[c][i]);
      sum += cnt;
      total++;
      if (cnt != NB) begin
        bad++; $display("FAIL en_count row=%0d got=%0d want=%0d", i, cnt, NB);
      end
    end
    total++;
    if (sum != NR * NB) begin
      bad++; $display("FAIL en_sum got=%0d want=%0d", sum, NR * NB);
    end
  endtask

  task automatic test_stall();
    clear_stim(); in_start[0] = 1; in_stall[4] = 1; in_stall[5] = 1;
    plan(40);
    drive(40, 1);
    for (int c = 0; c < 40; c++) begin
      total++;
      if ({o_en[c], o_load[c], o_clr[c], o_busy[c], o_done[c]} !==
          {x_en[c], x_load[c], x_clr[c], x_busy[c], x_done[c]}) begin
        bad++; $display("FAIL stall c=%0d got=%b want=%b", c,
          {o_en[c], o_load[c], o_clr[c], o_busy[c], o_done[c]},
          {x_en[c], x_load[c], x_clr[c], x_busy[c], x_done[c]});
      end
    end
    total++;
    if (o_en[5] !== '0 || o_en[6] !== '0 || o_done[DONE_STALL] !== 1'b1) begin
      bad++; $display("FAIL stall_fixed got=%b %b %b want=0 0 1", o_en[5], o_en[6], o_done[DONE_STALL]);
    end
  endtask

  task automatic test_start_held();
    int loads;
    clear_stim();
    for (int c = 0; c < 60; c++) in_start[c] = 1;
    plan(60);
    drive(60, 1);
    loads = 0;
    for (int c = 0; c < 60; c++) begin
      if (o_load[c] === 4'hF) loads++;
      total++;
      if ({o_en[c], o_load[c], o_clr[c], o_busy[c], o_done[c]} !==
          {x_en[c], x_load[c], x_clr[c], x_busy[c], x_done[c]}) begin
        bad++; $display("FAIL held c=%0d got=%b want=%b", c,
          {o_en[c], o_load[c], o_clr[c], o_busy[c], o_done[c]},
          {x_en[c], x_load[c], x_clr[c], x_busy[c], x_done[c]});
      end
    end
    total++;
    if (o_load[LOAD2_AT] !== 4'hF || o_load[LOAD2_AT-1] !== 4'h0) begin
      bad++; $display("FAIL held_second_load got=%h/%h want=0/f", o_load[LOAD2_AT-1], o_load[LOAD2_AT]);
    end
    total++;
    if (loads != (60 - 2) / (LOAD2_AT - 1) + 1) begin
      bad++; $display("FAIL held_load_count got=%0d want=%0d", loads, (60 - 2) / (LOAD2_AT - 1) + 1);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      clear_stim();
      for (int c = 0; c < 300; c++) begin
        in_start[c] = ($urandom_range(0, 3) == 0);
        in_stall[c] = ($urandom_range(0, 3) == 0);
      end
      plan(300);
      drive(300, 1);
      for (int c = 0; c < 300; c++) begin
        total++;
        if ({o_en[c], o_load[c], o_clr[c], o_busy[c], o_done[c]} !==
            {x_en[c], x_load[c], x_clr[c], x_busy[c], x_done[c]}) begin
          bad++; $display("FAIL random r=%0d c=%0d got=%b want=%b", r, c,
            {o_en[c], o_load[c], o_clr[c], o_busy[c], o_done[c]},
            {x_en[c], x_load[c], x_clr[c], x_busy[c], x_done[c]});
        end
      end
    end
  endtask

  initial begin
    reset = 1; start = 0; stall = 0;
    test_reset();
    test_basic();
    test_stall();
    test_start_held();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/feed_scheduler.md
Name: feed_scheduler

Overview:
Sequences a bank of N_ROWS byte-serial data feeders that drive the west edge of the systolic MAC array. One start request produces:
- a common load pulse to all feeders;
- diagonally skewed shift enables, so feeder i starts i cycles after feeder 0;
- a drain period for the array pipeline;
- a one-cycle done pulse.

It sits between the top-level control and the feeders' load (reset) and enable inputs.

Parameters:
N_ROWS, 4, number of feeders (array rows) sequenced
BYTES_PER_BURST, 7, shift enables issued to each feeder per burst (56-bit burst / 8)
DRAIN_CYCLES, 4, cycles waited after the last enable for the array to flush; minimum 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; returns block to IDLE
start  in  1  request a burst; sampled only in IDLE
stall  in  1  backpressure; freezes streaming while high
busy  out  1  high in every state except IDLE
feed_load  out  N_ROWS  one-cycle load pulse, wired to each feeder's reset/load input
feed_en  out  N_ROWS  per-feeder shift enable
mac_clear  out  1  clears array accumulators; coincident with feed_load
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset values: all outputs 0, state IDLE, step counter t=0, drain counter 0. Reset asserted mid-burst aborts immediately, with no done pulse.
- All outputs are registered (Moore). Enables change only on clk edges.
- States: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE: start=1 -> LOAD next cycle.
- LOAD (1 cycle): feed_load all ones, mac_clear=1, busy=1. Clears t. -> STREAM.
- STREAM: step counter t runs 0..T_LAST, where T_LAST = BYTES_PER_BURST+N_ROWS-2.
  - feed_en[i] = (t >= i) && (t < i+BYTES_PER_BURST).
  - With stall=1: feed_en is all zero and t holds; a stall in the cycle t would advance freezes t.
  - After the step with t=T_LAST is issued (not stalled) -> DRAIN.
- DRAIN: counts DRAIN_CYCLES cycles with feed_en=0. stall is ignored. -> DONE.
- DONE (1 cycle): done=1, busy=1. -> IDLE.
- start is ignored while busy. start in the DONE cycle is dropped. start in IDLE the cycle after DONE is accepted.
- Each feeder receives exactly BYTES_PER_BURST enable cycles per burst.
- Total latency with no stall, start sampled in cycle 0:
  - LOAD at cycle 1;
  - STREAM cycles 2..(2+T_LAST);
  - DRAIN next DRAIN_CYCLES cycles;
  - done in the following cycle.
- Width rules:
  - t width is $clog2(BYTES_PER_BURST+N_ROWS).
  - Drain counter width is $clog2(DRAIN_CYCLES+1).
  - Comparisons are unsigned; no wrap occurs within a burst.
- Elaboration checks: N_ROWS >= 1; BYTES_PER_BURST >= 1; DRAIN_CYCLES >= 1.

Optional Feature:
SHIFT_GAP_EN.
- Defined: each STREAM step lasts 2 cycles. Enables are asserted on the first cycle, and the second cycle is an idle gap with feed_en=0. stall sampled in either cycle extends the step. STREAM length doubles.
- Undefined: one step per cycle, as above.
- LOAD, DRAIN and DONE are unaffected in both cases.

Decomposition:
Shared package systolic_pkg holds:
- feed_state_e enum (IDLE, LOAD, STREAM, DRAIN, DONE);
- default constants FEED_BYTE_W=8, FEED_BURST_W=56 and FEED_BYTES=FEED_BURST_W/FEED_BYTE_W.

One natural sub-module, skew_en_gen: maps t plus the stream-active bit to the N_ROWS enable vector, with a registered output.

Test Plan:
- Basic burst (N_ROWS=4, BYTES=7, DRAIN=4), start pulse at cycle 0 -> expected response:
  - feed_load=4'hF and mac_clear=1 at cycle 1;
  - feed_en 0001, 0011, 0111, 1111, 1111, 1111, 1111, 1110, 1100, 1000 over cycles 2-11;
  - 0000 for cycles 12-15; done=1 at cycle 16; busy low at cycle 17.
- Per-feeder enable count over a burst = 7 for every i. Sum of all feed_en bits = 28.
- stall high for cycles 5-6 -> feed_en=0 in those cycles; the pattern resumes from t=3; done shifts to cycle 18.
- start held high continuously -> exactly one burst per IDLE visit; no start accepted while busy=1; the second LOAD occurs at cycle 18.
- reset asserted asynchronously mid-STREAM (cycle 6) -> all outputs 0 immediately, no done; a later start runs a clean full burst.
- With SHIFT_GAP_EN -> enables only on even offsets from cycle 2; STREAM spans 20 cycles; done at cycle 26.
